// File: rtl/decoder_scan_ctrl_if.sv
// Control/status bundle between a scan client and the decoder scan sequencer.
// The slave side belongs to decoder_scan_ctrl; the master side drives requests.
interface decoder_scan_ctrl_if #(
  parameter int DWELL_W = 8
);
  logic               start;
  logic               stop;
  logic               continuous;
  logic [3:0]         mask;
  logic [DWELL_W-1:0] dwell;
  logic [1:0]         inp;
  logic               enable;
  logic               busy;
  logic               done;

  modport master (
    output start, stop, continuous, mask, dwell,
    input  inp, enable, busy, done
  );

  modport slave (
    input  start, stop, continuous, mask, dwell,
    output inp, enable, busy, done
  );
endinterface

// File: rtl/decoder_scan_ctrl.sv
// Sequencer for a 2-to-4 decoder: sweeps the masked channels, holds each enabled
// for a programmable dwell, and blanks enable for one cycle between channels.
module decoder_scan_ctrl #(
  parameter int DWELL_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  decoder_scan_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    BLANK = 2'd2
  } state_t;

  state_t             r_state,  w_state_nxt;
  logic [1:0]         r_inp,    w_inp_nxt;
  logic               r_enable, w_enable_nxt;
  logic               r_busy,   w_busy_nxt;
  logic               r_done,   w_done_nxt;
  logic [3:0]         r_mask,   w_mask_nxt;
  logic [DWELL_W-1:0] r_dwell,  w_dwell_nxt;
  logic [DWELL_W-1:0] r_cnt,    w_cnt_nxt;
  logic [2:0]         w_next_ch;

  function automatic logic [1:0] f_lowest(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k]) r = 2'(k);
    end
    return r;
  endfunction

  // {found, index} of the nearest set mask bit strictly above idx.
  function automatic logic [2:0] f_next_above(input logic [3:0] m, input logic [1:0] idx);
    logic [2:0] r;
    r = 3'd0;
    for (int k = 3; k >= 0; k--) begin
      if (m[k] && (k > int'(idx))) r = {1'b1, 2'(k)};
    end
    return r;
  endfunction

  // Counter holds cycles remaining after the current one; dwell of 0 behaves as 1.
  function automatic logic [DWELL_W-1:0] f_cnt_load(input logic [DWELL_W-1:0] d);
    return (d == '0) ? '0 : d - DWELL_W'(1);
  endfunction

  assign w_next_ch = f_next_above(r_mask, r_inp);

  always_comb begin
    w_state_nxt  = r_state;
    w_inp_nxt    = r_inp;
    w_enable_nxt = r_enable;
    w_busy_nxt   = r_busy;
    w_done_nxt   = 1'b0;
    w_mask_nxt   = r_mask;
    w_dwell_nxt  = r_dwell;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      IDLE: begin
        w_enable_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        if (bus.start && !bus.stop && (bus.mask != 4'd0)) begin
          w_mask_nxt   = bus.mask;
          w_dwell_nxt  = bus.dwell;
          w_inp_nxt    = f_lowest(bus.mask);
          w_cnt_nxt    = f_cnt_load(bus.dwell);
          w_enable_nxt = 1'b1;
          w_busy_nxt   = 1'b1;
          w_state_nxt  = DRIVE;
        end
      end

      DRIVE: begin
        if (bus.stop) begin
          w_enable_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = IDLE;
        end else if (r_cnt == '0) begin
          w_enable_nxt = 1'b0;
          w_state_nxt  = BLANK;
        end else begin
          w_cnt_nxt = r_cnt - DWELL_W'(1);
        end
      end

      BLANK: begin
        if (bus.stop) begin
          w_enable_nxt = 1'b0;
          w_busy_nxt   = 1'b0;
          w_state_nxt  = IDLE;
        end else if (w_next_ch[2]) begin
          w_inp_nxt    = w_next_ch[1:0];
          w_cnt_nxt    = f_cnt_load(r_dwell);
          w_enable_nxt = 1'b1;
          w_state_nxt  = DRIVE;
        end else if (bus.continuous) begin
          // Wrap point: the only place a running sweep picks up new mask/dwell.
          w_mask_nxt  = bus.mask;
          w_dwell_nxt = bus.dwell;
          if (bus.mask != 4'd0) begin
            w_inp_nxt    = f_lowest(bus.mask);
            w_cnt_nxt    = f_cnt_load(bus.dwell);
            w_enable_nxt = 1'b1;
            w_state_nxt  = DRIVE;
          end else begin
            w_busy_nxt  = 1'b0;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end
        end else begin
          w_busy_nxt  = 1'b0;
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end

      default: begin
        w_enable_nxt = 1'b0;
        w_busy_nxt   = 1'b0;
        w_state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_inp    <= 2'd0;
      r_enable <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_mask   <= 4'd0;
      r_dwell  <= '0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_inp    <= w_inp_nxt;
      r_enable <= w_enable_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      r_mask   <= w_mask_nxt;
      r_dwell  <= w_dwell_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign bus.inp    = r_inp;
  assign bus.enable = r_enable;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_decoder_scan_ctrl.sv
// Randomized and directed bench for decoder_scan_ctrl against a schedule-based
// reference: each sweep is expanded into a queue of per-cycle (channel, enable) slots.
module tb_decoder_scan_ctrl;
  localparam int DWELL_W = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  decoder_scan_ctrl_if #(.DWELL_W(DWELL_W)) bus ();

  decoder_scan_ctrl #(.DWELL_W(DWELL_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] ch;
    logic       en;
  } slot_t;

  slot_t      q[$];
  logic [1:0] m_inp;
  logic       m_en, m_busy, m_done;

  int n_vec = 0;
  int n_err = 0;
  int busy_cnt = 0;
  int done_cnt = 0;

  function automatic void build(input logic [3:0] mk, input logic [DWELL_W-1:0] dw);
    int    d;
    slot_t s;
    d = (dw == 0) ? 1 : int'(dw);
    q.delete();
    for (int k = 0; k < 4; k++) begin
      if (mk[k]) begin
        for (int j = 0; j < d; j++) begin
          s.ch = 2'(k); s.en = 1'b1; q.push_back(s);
        end
        s.ch = 2'(k); s.en = 1'b0; q.push_back(s);
      end
    end
  endfunction

  task automatic take_slot();
    slot_t s;
    s = q.pop_front();
    m_inp  = s.ch;
    m_en   = s.en;
    m_busy = 1'b1;
  endtask

  task automatic model_step();
    m_done = 1'b0;
    if (m_busy && bus.stop) begin
      q.delete();
      m_en = 1'b0; m_busy = 1'b0;
    end else if (m_busy) begin
      if (q.size() == 0 && bus.continuous && bus.mask != 4'd0)
        build(bus.mask, bus.dwell);
      if (q.size() != 0) take_slot();
      else begin
        m_en = 1'b0; m_busy = 1'b0; m_done = 1'b1;
      end
    end else if (bus.start && !bus.stop && bus.mask != 4'd0) begin
      build(bus.mask, bus.dwell);
      take_slot();
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_inp = 2'd0; m_en = 1'b0; m_busy = 1'b0; m_done = 1'b0;
    end else begin
      model_step();
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      chk("inp",    32'(bus.inp),    32'(m_inp));
      chk("enable", 32'(bus.enable), 32'(m_en));
      chk("busy",   32'(bus.busy),   32'(m_busy));
      chk("done",   32'(bus.done),   32'(m_done));
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.done === 1'b1) done_cnt++;
    end
  endtask

  task automatic set_in(input logic st, input logic sp, input logic cn,
                        input logic [3:0] mk, input logic [DWELL_W-1:0] dw);
    bus.start = st; bus.stop = sp; bus.continuous = cn; bus.mask = mk; bus.dwell = dw;
  endtask

  int b0, d0;

  initial begin
    set_in(1'b0, 1'b0, 1'b0, 4'd0, '0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // One-shot 0101, dwell 2
    b0 = busy_cnt; d0 = done_cnt;
    set_in(1'b1, 1'b0, 1'b0, 4'b0101, 8'd2);
    tick(1);
    bus.start = 1'b0;
    bus.mask  = 4'b1111;
    tick(10);
    chk("s1_busy_len", 32'(busy_cnt - b0), 32'd6);
    chk("s1_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("s1_inp_hold", 32'(bus.inp), 32'd2);

    // One-shot 1111, dwell 0
    b0 = busy_cnt; d0 = done_cnt;
    set_in(1'b1, 1'b0, 1'b0, 4'b1111, 8'd0);
    tick(1);
    bus.start = 1'b0;
    tick(11);
    chk("s2_busy_len", 32'(busy_cnt - b0), 32'd8);
    chk("s2_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Continuous single channel, then mask change picked up at the wrap
    d0 = done_cnt;
    set_in(1'b1, 1'b0, 1'b1, 4'b1000, 8'd3);
    tick(1);
    bus.start = 1'b0;
    tick(12);
    bus.mask = 4'b0011;
    tick(12);
    chk("s3_no_done", 32'(done_cnt - d0), 32'd0);
    bus.continuous = 1'b0;
    tick(12);
    chk("s3_done_end", 32'(done_cnt - d0), 32'd1);

    // Continuous with mask cleared before the wrap
    d0 = done_cnt;
    set_in(1'b1, 1'b0, 1'b1, 4'b0110, 8'd1);
    tick(1);
    bus.start = 1'b0;
    bus.mask  = 4'd0;
    tick(10);
    chk("s4_done_cnt", 32'(done_cnt - d0), 32'd1);
    chk("s4_idle_en", 32'(bus.enable), 32'd0);

    // Stop in the second DRIVE cycle of channel 01
    d0 = done_cnt;
    set_in(1'b1, 1'b0, 1'b0, 4'b0110, 8'd3);
    tick(1);
    bus.start = 1'b0;
    tick(1);
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    chk("s5_stop_busy", 32'(bus.busy), 32'd0);
    tick(6);
    chk("s5_no_done", 32'(done_cnt - d0), 32'd0);
    set_in(1'b1, 1'b0, 1'b0, 4'b0010, 8'd2);
    tick(1);
    bus.start = 1'b0;
    chk("s5_restart_inp", 32'(bus.inp), 32'd1);
    tick(6);

    // Asynchronous reset in the middle of DRIVE
    set_in(1'b1, 1'b0, 1'b0, 4'b1100, 8'd5);
    tick(1);
    bus.start = 1'b0;
    tick(3);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_enable", 32'(bus.enable), 32'd0);
    chk("rst_inp",    32'(bus.inp),    32'd0);
    chk("rst_busy",   32'(bus.busy),   32'd0);
    tick(1);
    rst_n = 1'b1;
    b0 = busy_cnt;
    set_in(1'b1, 1'b0, 1'b0, 4'd0, 8'd2);
    tick(4);
    bus.start = 1'b0;
    chk("s6_no_resp", 32'(busy_cnt - b0), 32'd0);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      bus.start      = ($urandom_range(0, 3) == 0);
      bus.stop       = ($urandom_range(0, 19) == 0);
      bus.continuous = ($urandom_range(0, 2) == 0);
      bus.mask       = 4'($urandom);
      bus.dwell      = 8'($urandom_range(0, 4));
      tick(1);
    end
    set_in(1'b0, 1'b1, 1'b0, 4'd0, '0);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/decoder_scan_ctrl.md
Name: decoder_scan_ctrl

Overview:
- Upstream sequencer for the 2-to-4 decoder; drives the decoder's `inp[1:0]` and `enable` directly.
- Sweeps through the channels selected by a 4-bit mask and holds each channel enabled for a programmable dwell time.
- Inserts a one-cycle blanking gap (`enable=0`) between channels so the decoder never switches outputs while enabled.
- Supports one-shot and continuous sweeps, with start/stop control and busy/done status.

Parameters:
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  sweep request; sampled only in IDLE.
- stop  in  1  abort request; sampled while busy.
- continuous  in  1  1 = wrap and repeat at end of sweep; 0 = one-shot.
- mask  in  4  channel-select mask; bit k set = channel k is visited.
- dwell  in  DWELL_W  number of cycles each channel is enabled; 0 is treated as 1.
- inp  out  2  channel index to the decoder.
- enable  out  1  decoder enable.
- busy  out  1  high from the first DRIVE cycle through the last BLANK cycle.
- done  out  1  one-cycle pulse on normal sweep completion.

Behaviour:
- One clock; reset is asynchronous and active-low, ports clk and rst_n.
- Reset (asynchronous, immediate, also mid-sweep):
  - inp=2'b00, enable=0, busy=0, done=0.
  - State = IDLE; shadow mask and shadow dwell cleared.
- All outputs are registered.
- States: IDLE, DRIVE, BLANK.
- IDLE:
  - enable=0, busy=0; inp holds its last value.
  - start=1 and mask!=0 at edge N:
    - Capture mask and dwell into shadow registers.
    - inp = index of the lowest set mask bit.
    - Enter DRIVE; enable=1 and busy=1 visible from edge N.
  - start with mask==0: ignored; no done pulse.
  - start and stop both high in IDLE: start ignored.
- DRIVE:
  - enable=1.
  - Dwell counter runs for max(shadow dwell, 1) cycles, then the state moves to BLANK.
- BLANK:
  - Exactly one cycle; enable=0; inp unchanged.
  - Next channel = next set shadow-mask bit strictly above the current inp.
    - If one exists: inp updates to it and the state returns to DRIVE at the same edge.
  - If none exists (end of sweep):
    - continuous=1:
      - Re-sample mask and dwell into the shadow registers.
      - If the new mask is non-zero: go to its lowest set bit and enter DRIVE.
      - If the new mask is zero: go to IDLE with done=1.
    - continuous=0: go to IDLE with done=1 for one cycle; inp holds.
- inp changes only on edges entering DRIVE.
- Outside the continuous-mode wrap, mask and dwell changes during a sweep have no effect.
- A single-bit mask with continuous=1 alternates DRIVE(dwell)/BLANK(1) on the same channel indefinitely.
- stop=1 while busy:
  - Next edge: enable=0, busy=0, state IDLE.
  - No done pulse; inp holds.
- start while busy: ignored.
- continuous is sampled only at the end-of-sweep decision.
- Period per visited channel = dwell_eff + 1 cycles.
- One-shot sweep length = popcount(mask) × (dwell_eff + 1) cycles of busy.

Test Plan:
- mask=0101, dwell=2, continuous=0, start pulse:
  - enable pattern 1,1,0,1,1,0 with inp 00,00,00,10,10,10.
  - Then done=1 for one cycle; busy low from that cycle; inp stays 10.
- mask=1111, dwell=0, continuous=0:
  - Each channel is enabled for exactly 1 cycle; inp sequence 00,01,10,11.
  - busy lasts 8 cycles; one done pulse.
- mask=1000, dwell=3, continuous=1, run 12 cycles:
  - inp constant 11; enable repeats 1,1,1,0.
  - Then change mask to 0011: after the current BLANK, inp=00 and the sweep is 00,01; no done pulse.
- Continuous sweep, mask set to 0000 before the wrap:
  - Returns to IDLE after the final BLANK with a single done pulse; enable stays 0.
- stop asserted in the 2nd DRIVE cycle of channel 01:
  - Next edge: enable=0, busy=0; done never pulses.
  - A subsequent start with mask=0010 restarts at inp=01.
- rst_n driven low mid-DRIVE (async, between edges):
  - enable=0, inp=00, busy=0 immediately.
  - start with mask=0000 after release: no response.
